// File: rtl/semiring_reduce_pipe_pkg.sv
// Shared mode encodings and arithmetic helpers for the semiring reduction pipe.
// Helpers work at a fixed 64-bit width; callers truncate the result to W.
package semiring_pkg;

   localparam logic [1:0] MODE_MAXMIN  = 2'd0;
   localparam logic [1:0] MODE_MINMAX  = 2'd1;
   localparam logic [1:0] MODE_MINPLUS = 2'd2;
   localparam logic [1:0] MODE_MAXPLUS = 2'd3;

   localparam int SAT_MAXW = 64;
   localparam logic [SAT_MAXW:0] SAT_ONE = {{SAT_MAXW{1'b0}}, 1'b1};

   // Unsigned add of two w-bit values, clamped to 2^w-1 on carry-out.
   function automatic logic [SAT_MAXW-1:0] sat_add(input logic [SAT_MAXW-1:0] a,
                                                   input logic [SAT_MAXW-1:0] b,
                                                   input int unsigned w);
      logic [SAT_MAXW:0] s;
      logic [SAT_MAXW:0] lim;
      s   = {1'b0, a} + {1'b0, b};
      lim = (SAT_ONE << w) - SAT_ONE;
      return (s > lim) ? lim[SAT_MAXW-1:0] : s[SAT_MAXW-1:0];
   endfunction

   // Modes with even encoding reduce by min (identity all-ones); odd ones reduce by max.
   function automatic logic [SAT_MAXW-1:0] reduce_identity(input logic [1:0] mode);
      return mode[0] ? '0 : '1;
   endfunction

endpackage

// File: rtl/semiring_reduce_pipe_cell.sv
// One semiring operator: the mode's combine op or its reduce op, purely combinational.
module semiring_cell
   import semiring_pkg::*;
#(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [1:0]   mode,
   input  logic         sel_combine,
   output logic [W-1:0] z
);

   logic [W-1:0] mx, mn, sm;

   assign mx = (x > y) ? x : y;
   assign mn = (x < y) ? x : y;
   assign sm = W'(sat_add(SAT_MAXW'(x), SAT_MAXW'(y), W));

   always_comb begin
      z = mn;
      if (sel_combine) begin
         case (mode)
            MODE_MAXMIN: z = mx;
            MODE_MINMAX: z = mn;
            default:     z = sm;
         endcase
      end else begin
         z = mode[0] ? mx : mn;
      end
   end

endmodule

// File: rtl/semiring_reduce_pipe.sv
// Pipelined K-lane semiring dot-product reduction with a global-stall valid/ready pipe.
// Tree nodes live in a heap array: node n has children 2n+1 and 2n+2, leaves at K-1..2K-2.
module semiring_reduce_pipe
   import semiring_pkg::*;
#(
   parameter int W = 16,
   parameter int K = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [1:0]     in_mode,
   input  logic [K*W-1:0] in_a,
   input  logic [K*W-1:0] in_b,
   input  logic [W-1:0]   in_c,
   input  logic           in_acc_en,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic [1:0]     out_mode
);

   localparam int LOGK  = $clog2(K);
   localparam int NODES = 2*K - 1;

   logic [LOGK+1:0]           vld_pipe;
   logic [NODES-1:0][W-1:0]   node_d, node_q;
   logic [LOGK:0][1:0]        mode_q;
   logic [LOGK:0][W-1:0]      c_q;
   logic [LOGK:0]             acc_q;
   logic [W-1:0]              seed, fin_z;
   logic                      stall;

   assign out_valid = vld_pipe[LOGK+1];
   assign stall     = out_valid && !out_ready;
   assign in_ready  = !stall;

   genvar i, d, j;
   for (i = 0; i < K; i++) begin : g_comb
      semiring_cell #(.W(W)) u_cell (
         .x(in_a[i*W +: W]), .y(in_b[i*W +: W]), .mode(in_mode),
         .sel_combine(1'b1), .z(node_d[K-1+i]));
   end

   // Level d of the tree consumes the stage that holds level d+1 and its mode.
   for (d = 0; d < LOGK; d++) begin : g_lvl
      for (j = 0; j < (1 << d); j++) begin : g_node
         localparam int N = (1 << d) - 1 + j;
         semiring_cell #(.W(W)) u_cell (
            .x(node_q[2*N+1]), .y(node_q[2*N+2]), .mode(mode_q[LOGK-1-d]),
            .sel_combine(1'b0), .z(node_d[N]));
      end
   end

   assign seed = acc_q[LOGK] ? c_q[LOGK] : W'(reduce_identity(mode_q[LOGK]));

   semiring_cell #(.W(W)) u_final (
      .x(node_q[0]), .y(seed), .mode(mode_q[LOGK]), .sel_combine(1'b0), .z(fin_z));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         node_q   <= '0;
         mode_q   <= '0;
         c_q      <= '0;
         acc_q    <= '0;
         out_data <= '0;
         out_mode <= '0;
      end else if (!stall) begin
         vld_pipe <= {vld_pipe[LOGK:0], in_valid};
         node_q   <= node_d;
         mode_q   <= {mode_q[LOGK-1:0], in_mode};
         c_q      <= {c_q[LOGK-1:0], in_c};
         acc_q    <= {acc_q[LOGK-1:0], in_acc_en};
         out_data <= fin_z;
         out_mode <= mode_q[LOGK];
      end
   end

endmodule

// File: doc/semiring_reduce_pipe.md
Name: semiring_reduce_pipe

Overview:
- Pipelined, parametrised semiring dot-product reduction unit for the extended tensor core datapath.
- Each transaction takes K operand pairs (a_i, b_i) and an optional accumulator seed c, and produces one W-bit result:
  - out = reduce_i( combine(a_i, b_i) ), further reduced with c.
- Runtime-selectable semiring mode; the mode travels with the data.
- Valid/ready handshake on both sides; sits between the operand broadcast network and the accumulator writeback.

Parameters:
- W, 16: operand/result width, unsigned.
- K, 4: operand pairs per transaction. Power of two, K >= 2.
- LOGK, $clog2(K): derived, not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_mode  in  2  semiring mode, sampled with the transaction.
- in_a  in  K*W  a operands; lane i at [i*W +: W].
- in_b  in  K*W  b operands; lane i at [i*W +: W].
- in_c  in  W  accumulator seed.
- in_acc_en  in  1  1: reduce with in_c; 0: substitute reduce identity for in_c.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  W  result.
- out_mode  out  2  mode the result was computed under.

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0; out_data=0; out_mode=0; all data/mode pipeline registers 0.
- Modes (combine / reduce / reduce identity):
  - 0 MAXMIN: max / min / all-ones.
  - 1 MINMAX: min / max / 0.
  - 2 MINPLUS: sat_add / min / all-ones.
  - 3 MAXPLUS: sat_add / max / 0.
- Arithmetic rules:
  - All compares unsigned.
  - sat_add computes in W+1 bits and clamps to 2^W-1 on carry-out.
  - Ties: either operand may be selected (values are equal).
- Pipeline (total latency LOGK+2 cycles from accept to out_valid, for a non-stalled pipe):
  - S0: K combine cells, registered.
  - S1..S(LOGK): pairwise reduce-tree levels, one register level each.
  - S(LOGK+1): reduce of tree root with c (or identity); this is the output register.
- Per stage: each stage register holds valid, mode, and the c/acc_en sideband, so modes may change every cycle without bubbles or corruption.
- Flow control (global stall):
  - stall = out_valid && !out_ready.
  - When stall=1, every stage holds.
  - in_ready = !stall, combinational.
  - Bubbles are not collapsed.
- Throughput: one transaction per cycle when out_ready is held 1.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_mode hold stable.
- Simultaneous events: a transfer on out and an accept on in in the same cycle are both legal.
- Reset mid-operation: all in-flight transactions are discarded; none is emitted after rst_n deasserts.
- in_valid=0: a bubble (valid=0) enters S0. Data registers may update freely; only the valid bit matters.

Decomposition:
- Package semiring_pkg:
  - Mode localparams MODE_MAXMIN/MINMAX/MINPLUS/MAXPLUS.
  - Function sat_add(a, b, W).
  - Function reduce_identity(mode) returning all-ones or 0.
- Sub-module semiring_cell (parameter W; inputs x, y, mode, sel_combine; output z):
  - sel_combine=1 performs the mode's combine op.
  - sel_combine=0 performs the mode's reduce op.
  - Used in S0 (K instances), in the tree (K-1 instances), and in the final stage (1 instance).
- Top module: pipeline registers, valid/stall logic, generate loops.

Test Plan (W=16, K=4, latency 4):
- MAXMIN, a={1,5,3,9}, b={4,2,8,7}, c=6, acc_en=1, out_ready=1 -> out_data=4, out_mode=0, out_valid exactly 4 cycles after accept.
- MINPLUS saturation, a={0xFFF0,0x10,0x20,0x30}, b={0x20,1,2,3}, acc_en=0 -> lane sums {0xFFFF,0x11,0x22,0x33} -> out_data=0x0011.
- MAXPLUS, a={1,2,3,4}, b={1,1,1,1}, c=100, acc_en=1 -> out_data=100. Same vector with acc_en=0 -> out_data=5.
- Identity edges:
  - MINMAX, a=all 0, b=all 0xFFFF, acc_en=0 -> out_data=0.
  - MAXMIN, a=b=all 0xFFFF, acc_en=0 -> out_data=0xFFFF.
- Streaming/backpressure: 8 back-to-back transactions cycling modes 0-3, out_ready low for 4 cycles mid-stream -> in_ready low exactly while stalled, out_data stable during the stall, all 8 results in order with correct per-transaction modes, no loss or duplication.
- Reset mid-flight: 3 transactions in flight, pulse rst_n low asynchronously between clock edges -> out_valid=0 and out_data=0 immediately; no result emitted after release; the next fresh transaction completes with latency 4.
